// File: rtl/angstrom_pkg.sv
// Shared constants, FSM encoding and op codes for the RAM initiator.
// Burst support in ram_master is selected by RAM_MASTER_BURST_EN.
package angstrom_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 4;
   localparam int LEN_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACCESS  = 3'd1,
      S_CAPTURE = 3'd2,
      S_RESP    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Wraps naturally at 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] addr_inc(
      input logic [ADDR_W-1:0] a
   );
      return a + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/ram_burst_ctr.sv
// Burst address/beat counter for ram_master.
// Built only when RAM_MASTER_BURST_EN is defined.
module ram_burst_ctr
   import angstrom_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  start_cnt,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [LEN_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         cnt  <= '0;
      end else if (load) begin
         addr <= start_addr;
         cnt  <= start_cnt;
      end else if (step) begin
         addr <= addr_inc(addr);
         cnt  <= cnt - {{(LEN_W-1){1'b0}}, 1'b1};
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/ram_master.sv
// Single/burst request initiator sequencing the 4K x 4 RAM strobes.
// Define RAM_MASTER_BURST_EN to honour req_len (1..16 beats).
module ram_master
   import angstrom_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              done,
   output logic              ram_write,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out
);

   state_t            state_q;
   state_t            state_d;
   logic              ready_en_q;
   logic              op_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [ADDR_W-1:0] cur_addr;
   logic              last;
   logic              accept;
   logic              step;

   // ready_en holds req_ready low for the first cycle out of reset.
   assign accept = (state_q == S_IDLE) && ready_en_q && req_valid;

   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (op_q == OP_WR) begin
               if (last) state_d = S_DONE;
               else      step    = 1'b1;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: state_d = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  step    = 1'b1;
                  state_d = S_ACCESS;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ready_en_q <= 1'b0;
         op_q       <= OP_RD;
         data_q     <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
         if (accept) begin
            op_q   <= req_wr;
            data_q <= req_data;
         end
         if (state_q == S_CAPTURE) rsp_data_q <= ram_out;
      end
   end

`ifdef RAM_MASTER_BURST_EN
   ram_burst_ctr u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .step       (step),
      .start_addr (req_addr),
      .start_cnt  (req_len),
      .addr       (cur_addr),
      .last       (last)
   );
`else
   logic unused_burst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cur_addr <= '0;
      else if (accept) cur_addr <= req_addr;
   end

   // Every request is a single beat.
   assign last         = 1'b1;
   assign unused_burst = ^{req_len, step};
`endif

   assign req_ready = (state_q == S_IDLE) && ready_en_q;
   assign ram_write = (state_q == S_ACCESS) && (op_q == OP_WR);
   assign ram_read  = (state_q == S_ACCESS) && (op_q == OP_RD);
   assign ram_addr  = cur_addr;
   assign ram_in    = data_q;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a behavioural RAM and
// a transaction-level model checked every falling edge.
module tb_ram_master;
   import angstrom_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_wr = 1'b0;
   logic [11:0] req_addr = '0;
   logic [3:0]  req_data = '0;
   logic [3:0]  req_len = '0;
   logic        rsp_ready = 1'b1;
   logic        req_ready;
   logic        rsp_valid;
   logic [3:0]  rsp_data;
   logic        done;
   logic        ram_write;
   logic        ram_read;
   logic [11:0] ram_addr;
   logic [3:0]  ram_in;
   logic [3:0]  ram_out;

`ifdef RAM_MASTER_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   always #5 clk = ~clk;

   ram_master dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .done      (done),
      .ram_write (ram_write),
      .ram_read  (ram_read),
      .ram_addr  (ram_addr),
      .ram_in    (ram_in),
      .ram_out   (ram_out)
   );

   // Behavioural RAM
   logic [3:0] mem [4096];
   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_in;
      if (ram_read)  ram_out <= mem[ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input bit ok, input string nm,
                      input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] qget(input logic [11:0] q[$],
                                        input int i);
      if (q.size() > i) return q[i];
      return 12'bx;
   endfunction

   // Model state
   typedef struct {
      bit          wr;
      logic [11:0] a;
      logic [3:0]  d;
   } beat_t;

   beat_t       bq[$];
   logic [11:0] rq[$];
   logic [3:0]  gold [4096];
   logic [11:0] wr_log[$];
   logic [11:0] rsp_log[$];
   beat_t       mb;
   logic [11:0] ma;
   bit          busy = 0;
   bit          alive;
   bit          first_pending = 0;
   bit          pstall = 0;
   bit          pvalid = 0;
   logic [3:0]  pdata = '0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          rd_cyc = 0;
   int          last_evt = 0;
   int          done_cnt = 0;
   int          stall_cnt = 0;
   int          nb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk({req_ready, rsp_valid, done, ram_write, ram_read} == 5'b0
             && rsp_data == 4'h0 && ram_addr == 12'h0 && ram_in == 4'h0,
             "reset_outputs",
             {req_ready, rsp_valid, done, ram_write, ram_read}, 0);
         bq.delete();
         rq.delete();
         busy   = 0;
         pstall = 0;
         pvalid = 0;
         first_pending = 0;
      end else begin
         chk(req_ready == (alive && !busy), "req_ready",
             req_ready, alive && !busy);
         chk(!(ram_write && ram_read), "strobe_exclusive",
             {ram_write, ram_read}, 0);
         if (rsp_valid)
            chk(!ram_write && !ram_read, "strobe_in_resp",
                {ram_write, ram_read}, 0);
         if (ram_write || ram_read) begin
            if (bq.size() == 0) begin
               chk(0, "unexpected_strobe", {ram_write, ram_read}, 0);
            end else begin
               mb = bq.pop_front();
               if (first_pending)
                  chk(cyc == acc_cyc + 1, "first_access_lat",
                      cyc - acc_cyc, 1);
               first_pending = 0;
               chk(ram_write == mb.wr, "strobe_op", ram_write, mb.wr);
               chk(ram_addr == mb.a, "ram_addr", ram_addr, mb.a);
               if (ram_write) begin
                  chk(ram_in == mb.d, "ram_in", ram_in, mb.d);
                  gold[mb.a] = mb.d;
                  wr_log.push_back(ram_addr);
                  if (bq.size() == 0) last_evt = cyc;
               end else begin
                  rq.push_back(mb.a);
                  rd_cyc = cyc;
               end
            end
         end
         if (rsp_valid && !pvalid)
            chk(cyc - rd_cyc == 2, "rsp_latency", cyc - rd_cyc, 2);
         if (pstall) begin
            chk(rsp_valid, "stall_valid_hold", rsp_valid, 1);
            chk(rsp_data == pdata, "stall_data_stable", rsp_data, pdata);
         end
         if (rsp_valid && !rsp_ready) stall_cnt++;
         if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
               chk(0, "unexpected_rsp", rsp_data, 0);
            end else begin
               ma = rq.pop_front();
               chk(rsp_data == gold[ma], "rsp_data", rsp_data, gold[ma]);
               rsp_log.push_back({8'h0, rsp_data});
               if (bq.size() == 0) last_evt = cyc;
            end
         end
         if (done) begin
            done_cnt++;
            chk(busy, "done_without_req", done, 0);
            chk(bq.size() == 0 && rq.size() == 0, "done_early",
                bq.size() + rq.size(), 0);
            chk(cyc == last_evt + 1, "done_timing", cyc - last_evt, 1);
            busy = 0;
         end
         if (req_valid && req_ready) begin
            busy = 1;
            acc_cyc = cyc;
            first_pending = 1;
            nb = BURST ? int'(req_len) + 1 : 1;
            for (int i = 0; i < nb; i++) begin
               mb.wr = req_wr;
               mb.a  = 12'(int'(req_addr) + i);
               mb.d  = req_data;
               bq.push_back(mb);
            end
         end
         pstall = rsp_valid && !rsp_ready;
         pdata  = rsp_data;
         pvalid = rsp_valid;
      end
   end

   task automatic do_req(input bit wr, input logic [11:0] a,
                         input logic [3:0] d, input logic [3:0] l);
      int n;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_data  = d;
      req_len   = l;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) chk(0, "accept_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) chk(0, "done_timeout", 0, 1);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic clear_logs();
      wr_log.delete();
      rsp_log.delete();
      done_cnt  = 0;
      stall_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      int target;
      int wcount;
      for (int i = 0; i < 4096; i++) begin
         mem[i]  = 4'h0;
         gold[i] = 4'h0;
      end

      // Reset and release
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk(req_ready == 1'b0, "ready_at_release", req_ready, 0);
      @(posedge clk); #1;
      chk(req_ready == 1'b1, "ready_after_release", req_ready, 1);

      // Single writes then reads
      clear_logs();
      do_req(1'b1, 12'h000, 4'h3, 4'h0);
      do_req(1'b1, 12'h001, 4'h1, 4'h0);
      do_req(1'b0, 12'h001, 4'h0, 4'h0);
      do_req(1'b0, 12'h000, 4'h0, 4'h0);
      settle();
      chk(rsp_log.size() == 2, "single_rsp_count", rsp_log.size(), 2);
      chk(qget(rsp_log, 0) === 12'h1, "single_rd0", qget(rsp_log, 0), 1);
      chk(qget(rsp_log, 1) === 12'h3, "single_rd1", qget(rsp_log, 1), 3);
      chk(done_cnt == 4, "single_done_count", done_cnt, 4);

      // Burst fill across the address wrap
      clear_logs();
      do_req(1'b1, 12'hFFE, 4'hA, 4'd3);
      settle();
      chk(done_cnt == 1, "fill_done_once", done_cnt, 1);
`ifdef RAM_MASTER_BURST_EN
      chk(wr_log.size() == 4, "fill_writes", wr_log.size(), 4);
      chk(qget(wr_log, 0) === 12'hFFE, "fill_a0", qget(wr_log, 0), 12'hFFE);
      chk(qget(wr_log, 1) === 12'hFFF, "fill_a1", qget(wr_log, 1), 12'hFFF);
      chk(qget(wr_log, 2) === 12'h000, "fill_a2", qget(wr_log, 2), 0);
      chk(qget(wr_log, 3) === 12'h001, "fill_a3", qget(wr_log, 3), 1);
      chk(mem[12'h001] == 4'hA, "fill_mem_wrap", mem[12'h001], 4'hA);
      target = 2;
`else
      chk(wr_log.size() == 1, "fill_writes", wr_log.size(), 1);
      chk(qget(wr_log, 0) === 12'hFFE, "fill_a0", qget(wr_log, 0), 12'hFFE);
      chk(mem[12'hFFF] == 4'h0, "fill_no_beat2", mem[12'hFFF], 0);
      target = 1;
`endif

      // Burst read with back-pressure on one beat
      clear_logs();
      fork
         do_req(1'b0, 12'hFFE, 4'h0, 4'd3);
         begin
            bit pv;
            pv = 0;
            n  = 0;
            k  = 0;
            while (n < target && k < 100) begin
               @(posedge clk); #1;
               if (rsp_valid && !pv) n++;
               pv = rsp_valid;
               k++;
            end
            rsp_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 rsp_ready = 1'b1;
         end
      join
      settle();
      chk(stall_cnt == 5, "stall_cycles", stall_cnt, 5);
      chk(done_cnt == 1, "bread_done_once", done_cnt, 1);
      chk(rsp_log.size() == (BURST ? 4 : 1), "bread_rsp_count",
          rsp_log.size(), BURST ? 4 : 1);
      for (int i = 0; i < rsp_log.size(); i++)
         chk(rsp_log[i] == 12'hA, "bread_data", rsp_log[i], 4'hA);

      // Reset in the middle of a 16-beat write
      clear_logs();
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 12'h100;
      req_data  = 4'h5;
      req_len   = 4'd15;
      k = 0;
      while (!req_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      k = 0;
      while (n < target && k < 50) begin
         @(negedge clk);
         if (ram_write) n++;
         k++;
      end
      chk(n == target, "midrst_reach_beat", n, target);
      #2 rst_n = 1'b0;
      #1;
      chk(ram_write == 1'b0, "midrst_write_drop", ram_write, 0);
      chk(req_ready == 1'b0, "midrst_ready_low", req_ready, 0);
      wcount = wr_log.size();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk(req_ready == 1'b0, "midrst_ready_release", req_ready, 0);
      @(posedge clk); #1;
      chk(req_ready == 1'b1, "midrst_ready_after", req_ready, 1);
      repeat (6) @(posedge clk);
      #1;
      chk(wr_log.size() == wcount, "midrst_no_more_writes",
          wr_log.size(), wcount);
`ifdef RAM_MASTER_BURST_EN
      chk(mem[12'h100] == 4'h5, "midrst_beat1_kept", mem[12'h100], 5);
      chk(mem[12'h101] == 4'h0, "midrst_beat2_dropped", mem[12'h101], 0);
`else
      chk(mem[12'h100] == 4'h0, "midrst_beat_dropped", mem[12'h100], 0);
`endif

      // req_len = 7 write
      clear_logs();
      do_req(1'b1, 12'h200, 4'h6, 4'd7);
      settle();
      chk(done_cnt == 1, "len7_done_once", done_cnt, 1);
`ifdef RAM_MASTER_BURST_EN
      chk(wr_log.size() == 8, "len7_writes", wr_log.size(), 8);
      chk(mem[12'h207] == 4'h6, "len7_last", mem[12'h207], 6);
`else
      chk(wr_log.size() == 1, "len7_writes", wr_log.size(), 1);
      chk(mem[12'h201] == 4'h0, "len7_no_beat2", mem[12'h201], 0);
`endif
      do_req(1'b0, 12'h200, 4'h0, 4'd0);
      settle();
      chk(qget(rsp_log, 0) === 12'h6, "len7_readback",
          qget(rsp_log, 0), 6);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
